// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy/fill sequencer.
// Width defaults match the data_memory port widths.
package dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_CAP  = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dma_copy_engine.sv
// Memory-initiator sequencer: forward byte copy or constant fill.
// All outputs are registered from next-state values.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int BYTE_WIDTH = BYTE_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [15:0]           i_length,
  input  logic [BYTE_WIDTH-1:0] i_fill_byte,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data_in,
  input  logic [BYTE_WIDTH-1:0] i_mem_data_out
);

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_src, w_src;
  logic [ADDR_WIDTH-1:0] r_dst, w_dst;
  logic [15:0]           r_cnt, w_cnt;
  logic                  r_mode, w_mode;
  logic [BYTE_WIDTH-1:0] r_fill, w_fill;
  logic [BYTE_WIDTH-1:0] r_byte, w_byte;

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;
  logic [BYTE_WIDTH-1:0] w_wbyte;

  always_comb begin
    w_next = r_state;
    w_src  = r_src;
    w_dst  = r_dst;
    w_cnt  = r_cnt;
    w_mode = r_mode;
    w_fill = r_fill;
    w_byte = r_byte;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_src  = i_src_addr;
          w_dst  = i_dst_addr;
          w_cnt  = i_length;
          w_mode = i_mode;
          w_fill = i_fill_byte;
          if (i_length == 16'd0)
            w_next = S_DONE;
          else if (i_mode == MODE_FILL)
            w_next = S_WR;
          else
            w_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: w_next = S_RD_CAP;
      S_RD_CAP: begin
        w_byte = i_mem_data_out;
        w_next = S_WR;
      end
      S_WR: begin
        w_src = r_src + 1'b1;
        w_dst = r_dst + 1'b1;
        w_cnt = r_cnt - 16'd1;
        if (r_cnt == 16'd1)
          w_next = S_DONE;
        else if (r_mode == MODE_FILL)
          w_next = S_WR;
        else
          w_next = S_RD_ADDR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus values for the cycle we are about to enter.
  always_comb begin
    w_we    = (w_next == S_WR);
    w_addr  = '0;
    w_din   = '0;
    w_wbyte = (w_mode == MODE_FILL) ? w_fill : w_byte;
    unique case (w_next)
      S_RD_ADDR, S_RD_CAP: w_addr = w_src;
      S_WR: begin
        w_addr = w_dst;
        w_din  = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_wbyte};
      end
      default: w_addr = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_src          <= '0;
      r_dst          <= '0;
      r_cnt          <= '0;
      r_mode         <= MODE_COPY;
      r_fill         <= '0;
      r_byte         <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_mem_write_en <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_data_in  <= '0;
    end else begin
      r_state        <= w_next;
      r_src          <= w_src;
      r_dst          <= w_dst;
      r_cnt          <= w_cnt;
      r_mode         <= w_mode;
      r_fill         <= w_fill;
      r_byte         <= w_byte;
      o_busy         <= (w_next != S_IDLE);
      o_done         <= (w_next == S_DONE);
      o_mem_write_en <= w_we;
      o_mem_addr     <= w_addr;
      o_mem_data_in  <= w_din;
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine with a byte memory responder and a
// loop-based reference model of copy/fill results and timing.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic [7:0]  fill_byte;
  logic        busy;
  logic        done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [7:0]  mem_dout;

  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [7:0]  tb_data = '0;

  logic [7:0]  mem  [65536];
  logic [7:0]  refm [65536];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_mode         (mode),
    .i_src_addr     (src_addr),
    .i_dst_addr     (dst_addr),
    .i_length       (length),
    .i_fill_byte    (fill_byte),
    .o_busy         (busy),
    .o_done         (done),
    .o_mem_write_en (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_data_in  (mem_din),
    .i_mem_data_out (mem_dout)
  );

  // data_memory responder: registered read, write at the clock edge
  always @(posedge clk) begin
    if (tb_we)
      mem[tb_addr] <= tb_data;
    else if (mem_we)
      mem[mem_addr] <= mem_din[7:0];
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
    refm[a] = v;
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== refm[i]) bad++;
    chk({tag, " mem"}, bad, 0);
  endtask

  task automatic model(input logic m, input logic [15:0] s,
                       input logic [15:0] d, input logic [15:0] l,
                       input logic [7:0] f);
    logic [15:0] sa, da;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      refm[da] = m ? f : refm[sa];
    end
  endtask

  task automatic run_cmd(input logic m, input logic [15:0] s,
                         input logic [15:0] d, input logic [15:0] l,
                         input logic [7:0] f, input int restart_at,
                         input string tag);
    int exp, c, wr, extra;
    exp = (l == 0) ? 1 : (m ? 1 + int'(l) : 1 + 3 * int'(l));
    model(m, s, d, l, f);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    src_addr = s;
    dst_addr = d;
    length = l;
    fill_byte = f;
    @(posedge clk);
    c = 0;
    wr = 0;
    do begin
      @(negedge clk);
      c++;
      start = (c == restart_at);
      if (c == restart_at) begin
        mode = 1'($urandom_range(0, 1));
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        length = 16'($urandom_range(1, 4));
        fill_byte = 8'($urandom);
      end else begin
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        length = 16'($urandom);
      end
      if (c == 1) chk({tag, " busy"}, busy, 1);
      if (mem_we) wr++;
    end while (!done && c < exp + 8);
    chk({tag, " done_cycle"}, c, exp);
    chk({tag, " writes"}, wr, l);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " idle"}, {busy, done}, 2'b00);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk({tag, " quiet"}, extra, 0);
    cmp_mem(tag);
  endtask

  initial begin
    int wr, c, bad;
    logic        rm;
    logic [15:0] rs, rd, rl;
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    fill_byte = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst din", mem_din, 0);
    for (int i = 0; i < 65536; i++) refm[i] = mem[i];
    reset = 1'b0;

    poke(16'h0010, 8'h11);
    poke(16'h0011, 8'h22);
    poke(16'h0012, 8'h33);
    poke(16'h0013, 8'h44);
    for (int i = 0; i < 8; i++) begin
      poke(16'(i), 8'($urandom));
      poke(16'hFFF8 + 16'(i), 8'($urandom));
    end

    run_cmd(1'b0, 16'h0010, 16'h0020, 16'd4, 8'h00, 0, "copy4");
    chk("copy4 byte0", refm[16'h0020], 8'h11);
    chk("copy4 byte3", refm[16'h0023], 8'h44);
    run_cmd(1'b1, 16'h0000, 16'h0005, 16'd3, 8'hA5, 0, "fill3");
    run_cmd(1'b0, 16'h0010, 16'h0030, 16'd0, 8'h00, 0, "len0");
    run_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h5C, 0, "fillwrap");
    chk("fillwrap 0000", refm[16'h0000], 8'h5C);
    run_cmd(1'b0, 16'h0010, 16'h0050, 16'd4, 8'h00, 6, "restart");
    run_cmd(1'b1, 16'h0000, 16'h0060, 16'd2, 8'h3C, 3, "restart_done");
    run_cmd(1'b0, 16'h0010, 16'h0012, 16'd4, 8'h00, 0, "overlap");
    run_cmd(1'b0, 16'hFFFC, 16'h0070, 16'd6, 8'h00, 0, "copywrap");

    for (int n = 0; n < 10; n++) begin
      rm = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                       : 16'($urandom_range(0, 15));
      rd = 16'($urandom_range(0, 127));
      rl = 16'($urandom_range(0, 6));
      run_cmd(rm, rs, rd, rl, 8'($urandom), 0, $sformatf("rand%0d", n));
    end

    // reset in the second write cycle of a 4-byte copy
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    src_addr = 16'h0010;
    dst_addr = 16'h0040;
    length = 16'd4;
    @(posedge clk);
    wr = 0;
    c = 0;
    bad = 0;
    while (wr < 2 && c < 20) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (mem_we) wr++;
    end
    chk("rstmid reach", wr, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid busy", busy, 0);
    chk("rstmid we", mem_we, 0);
    model(1'b0, 16'h0010, 16'h0040, 16'd2, 8'h00);
    repeat (6) begin
      @(negedge clk);
      if (done || mem_we) bad++;
    end
    chk("rstmid quiet", bad, 0);
    cmp_mem("rstmid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
